vga_frame_fetch: RTL and testbench

Pixel source for the VGA output stage: walks a stored IMG_W x IMG_H RGB444 image in lock-step with the VGA timing generator's active-video flags, replicating each stored pixel SCALE x SCALE times, and drives the 4-bit r/g/b inputs of the colour stage. Pixels flagged in memory are replaced by a mask colour when masking is enabled. Everything outside the scaled image but inside active video shows a border colour; blanking is forced black.

---
 rtl/vga_frame_fetch.sv | 189 ++++++++++++++++++
 tb/tb_vga_frame_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_fetch.sv
// Pixel source for VGA: walks a stored RGB444 image in step with active-video ticks, SCALE x SCALE replicated.
// Latency one pixel tick (address at t+1, colour at t+2); no backpressure, paced entirely by pix_en.
module vga_frame_fetch #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int SCALE  = 4,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              h_active,
  input  logic              v_active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [12:0]       mem_data,
  input  logic              mask_en,
  input  logic [11:0]       mask_rgb,
  input  logic [11:0]       border_rgb,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              frame_done
);

  localparam int IXW = $clog2(IMG_W + 1);
  localparam int IYW = $clog2(IMG_H + 1);
  localparam int SXW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [IXW-1:0]    IX_END   = IXW'(IMG_W);
  localparam logic [IYW-1:0]    IY_END   = IYW'(IMG_H);
  localparam logic [IYW-1:0]    IY_LAST  = IYW'(IMG_H - 1);
  localparam logic [SXW-1:0]    S_LAST   = SXW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  typedef enum logic {SYNC, RUN} state_t;
  typedef enum logic [1:0] {PK_BLANK, PK_BORDER, PK_IMAGE} pix_kind_t;

  state_t            state_q, state_d;
  logic              run;

  logic [SXW-1:0]    sx_q, sx_d;
  logic [SXW-1:0]    sy_q, sy_d;
  logic [IXW-1:0]    ix_q, ix_d;
  logic [IYW-1:0]    iy_q, iy_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              h_prev_q, h_prev_d;
  logic              v_prev_q, v_prev_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              done_q, done_d;
  pix_kind_t         kind_q, kind_d;
  logic              stage_vld_q, stage_vld_d;
  logic [11:0]       rgb_q, rgb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Only leave SYNC during vertical blanking so the first fetched frame is whole.
  always_comb begin
    state_d = state_q;
    if (state_q == SYNC && pix_en && !v_active) begin
      state_d = RUN;
    end
  end

  always_comb begin
    run = (state_q == RUN);
  end

  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    base_d      = base_q;
    h_prev_d    = h_prev_q;
    v_prev_d    = v_prev_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    done_d      = 1'b0;
    kind_d      = PK_BLANK;
    stage_vld_d = 1'b0;

    if (pix_en) begin
      h_prev_d    = h_active;
      v_prev_d    = v_active;
      stage_vld_d = 1'b1;
      if (run) begin
        if (v_prev_q && !v_active) begin
          // Frame end beats a coincident line end.
          sx_d   = '0;
          sy_d   = '0;
          ix_d   = '0;
          iy_d   = '0;
          base_d = '0;
          done_d = 1'b1;
        end else if (v_active && h_prev_q && !h_active) begin
          sx_d = '0;
          ix_d = '0;
          if (sy_q == S_LAST) begin
            sy_d = '0;
            if (iy_q < IY_END) begin
              iy_d = iy_q + 1'b1;
              if (iy_q < IY_LAST) begin
                base_d = base_q + ROW_STEP;
              end
            end
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end else if (h_active && v_active) begin
          if (ix_q < IX_END && iy_q < IY_END) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = base_q + ADDR_W'(ix_q);
            kind_d     = PK_IMAGE;
          end else begin
            kind_d = PK_BORDER;
          end
          if (sx_q == S_LAST) begin
            sx_d = '0;
            if (ix_q < IX_END) begin
              ix_d = ix_q + 1'b1;
            end
          end else begin
            sx_d = sx_q + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    if (stage_vld_q) begin
      case (kind_q)
        PK_BORDER: rgb_d = border_rgb;
        PK_IMAGE:  rgb_d = (mem_data[12] && mask_en) ? mask_rgb : mem_data[11:0];
        default:   rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      ix_q        <= '0;
      iy_q        <= '0;
      base_q      <= '0;
      h_prev_q    <= 1'b0;
      v_prev_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      done_q      <= 1'b0;
      kind_q      <= PK_BLANK;
      stage_vld_q <= 1'b0;
      rgb_q       <= 12'h000;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      base_q      <= base_d;
      h_prev_q    <= h_prev_d;
      v_prev_q    <= v_prev_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      done_q      <= done_d;
      kind_q      <= kind_d;
      stage_vld_q <= stage_vld_d;
      rgb_q       <= rgb_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign frame_done = done_q;
  assign r          = rgb_q[11:8];
  assign g          = rgb_q[7:4];
  assign b          = rgb_q[3:0];

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Randomised bench for vga_frame_fetch: small 4x2 image, SCALE 2, scoreboard of reads, colours and frame pulses.
module tb_vga_frame_fetch;
  localparam int IW = 4, IH = 2, SC = 2, AW = 3;
  localparam int H_ACT = 10, H_BLK = 3, V_ACT = 6, V_BLK = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pix_en = 1'b0, h_active = 1'b0, v_active = 1'b0, mask_en = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [12:0]   mem_data;
  logic [11:0]   mask_rgb = 12'h000, border_rgb = 12'h000;
  logic [3:0]    r, g, b;
  logic          frame_done;

  logic [12:0]   mem [IW*IH];
  int            checks = 0, failures = 0;
  int            cyc = 0;

  typedef struct {int cyc; logic [11:0] val;} exp_t;
  exp_t          rdq[$], rgbq[$];
  int            doneq[$];
  exp_t          rd_x, rgb_x;
  int            done_x;
  logic [11:0]   cur_rgb, prev_rgb = 12'h000;
  bit            fast = 0;

  // reference model state: screen position within the current frame
  bit            synced = 0, pv = 0, ph = 0;
  int            px = 0, ln = 0;

  vga_frame_fetch #(.IMG_W(IW), .IMG_H(IH), .SCALE(SC), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_active(h_active), .v_active(v_active),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mask_en(mask_en),
    .mask_rgb(mask_rgb), .border_rgb(border_rgb), .r(r), .g(g), .b(b), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_data = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called just after a clock edge; the DUT samples this tick at the next edge e.
  task automatic tick(input logic h, input logic v);
    int e, gap, a, xi, yi;
    logic [11:0] col;
    e = cyc + 1;
    pix_en = 1'b1; h_active = h; v_active = v; mask_en = 1'($urandom);
    col = 12'h000;
    if (!synced) begin
      if (!v) begin synced = 1; px = 0; ln = 0; end
    end else begin
      if (pv && !v) begin
        doneq.push_back(e); px = 0; ln = 0;
      end else if (v && ph && !h) begin
        px = 0; ln++;
      end
      if (h && v) begin
        xi = px / SC; yi = ln / SC;
        if (xi < IW && yi < IH) begin
          a = yi * IW + xi;
          rdq.push_back('{e, 12'(a)});
          col = (mask_en && mem[a][12]) ? mask_rgb : mem[a][11:0];
        end else begin
          col = border_rgb;
        end
        px++;
      end
    end
    ph = h; pv = v;
    rgbq.push_back('{e + 1, col});
    gap = fast ? 4 : int'($urandom_range(4, 7));
    @(posedge clk);
    #1 pix_en = 1'b0;
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'({r, g, b}), 32'h0);
    check("async_rst_rd", 32'(mem_rd), 32'h0);
    check("async_rst_addr", 32'(mem_addr), 32'h0);
    check("async_rst_done", 32'(frame_done), 32'h0);
    synced = 0; pv = 0; ph = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_frame(input int start_line, input int rst_line, input bit simul);
    bit vis;
    int nb;
    for (int l = start_line; l < V_ACT + V_BLK; l++) begin
      vis = (l < V_ACT);
      nb = (simul && l == V_ACT - 1) ? 0 : H_BLK;
      for (int p = 0; p < H_ACT; p++) begin
        if (l == rst_line && p == 5) pulse_reset();
        tick(vis, vis);
      end
      for (int p = 0; p < nb; p++) tick(1'b0, vis);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        if (rdq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual addr=%0d required=no read (cycle %0d)", mem_addr, cyc);
        end else begin
          rd_x = rdq.pop_front();
          check("rd_addr", 32'(mem_addr), 32'(rd_x.val));
          check("rd_cycle", cyc, rd_x.cyc);
        end
      end
      while (rdq.size() != 0 && rdq[0].cyc < cyc) begin
        rd_x = rdq.pop_front();
        checks++; failures++;
        $display("FAIL rd_missing actual=none required addr=%0d at cycle %0d", rd_x.val, rd_x.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) begin
        if (doneq.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=pulse required=none (cycle %0d)", cyc);
        end else begin
          done_x = doneq.pop_front();
          check("done_cycle", cyc, done_x);
        end
      end
      while (doneq.size() != 0 && doneq[0] < cyc) begin
        done_x = doneq.pop_front();
        checks++; failures++;
        $display("FAIL done_missing actual=none required=pulse at cycle %0d", done_x);
      end
    end
  end

  always @(negedge clk) begin
    cur_rgb = {r, g, b};
    if (rst_n) begin
      while (rgbq.size() != 0 && rgbq[0].cyc < cyc) begin
        rgb_x = rgbq.pop_front();
        checks++; failures++;
        $display("FAIL rgb_missed actual=none required=%03h at cycle %0d", rgb_x.val, rgb_x.cyc);
      end
      if (rgbq.size() != 0 && rgbq[0].cyc == cyc) begin
        rgb_x = rgbq.pop_front();
        check("rgb", 32'(cur_rgb), 32'(rgb_x.val));
      end else if (cur_rgb != prev_rgb) begin
        checks++; failures++;
        $display("FAIL rgb_untimed_change actual=%03h required=%03h (cycle %0d)", cur_rgb, prev_rgb, cyc);
      end
    end
    prev_rgb = cur_rgb;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < IW * IH; i++) mem[i] = 13'($urandom);
    mem[0] = 13'h1ABC;
    mem[1] = 13'h0ABC;
    mem[5] = 13'h1123;
    mask_rgb = 12'h0F0;
    border_rgb = 12'h5A3;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_r", 32'(r), 32'h0);
    check("reset_g", 32'(g), 32'h0);
    check("reset_b", 32'(b), 32'h0);
    check("reset_addr", 32'(mem_addr), 32'h0);
    check("reset_rd", 32'(mem_rd), 32'h0);
    check("reset_done", 32'(frame_done), 32'h0);

    // release in the middle of a frame: must stay dark until vertical blanking
    rst_n = 1'b1;
    run_frame(2, -1, 1'b0);
    run_frame(0, -1, 1'b1);
    fast = 1;
    run_frame(0, -1, 1'b0);
    fast = 0;
    border_rgb = 12'($urandom);
    mask_rgb = 12'($urandom);
    run_frame(0, 3, 1'b1);
    run_frame(0, -1, 1'b0);
    run_frame(0, -1, 1'b1);

    repeat (10) @(posedge clk);
    #1;
    check("rd_queue_drained", 32'(rdq.size()), 32'h0);
    check("rgb_queue_drained", 32'(rgbq.size()), 32'h0);
    check("done_queue_drained", 32'(doneq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
